pcie_gen_tramas: RTL
====================

Name: pcie_gen_tramas

Overview:
- Synthesizable, parametrised byte-stream frame source for the ByteTX-to-ByteRX path.
- Emits COM alignment symbols followed by generated payload, per frame, over LANES byte lanes.
- Payload comes from a counter or an 8-bit LFSR and is gated by a valid/ready handshake.
- Drives the TX byte interface in place of fixed bench stimulus, so multi-lane and backpressure cases run in simulation and on hardware.

Parameters:
- LANES, 1, byte lanes per beat; DATA width = 8*LANES.
- SYNC_LEN, 2, COM beats per frame (>=1).
- PAYLOAD_LEN, 4, payload beats per frame (>=1).
- COM, 8'hBC, K-symbol byte for alignment beats.

Ports:
- CLK  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  run request; sampled in IDLE and at frame end.
- mode  in  1  0 = counter payload, 1 = LFSR payload; latched at frame start.
- seed  in  8  payload seed; latched at frame start.
- ready  in  1  downstream accepts the current beat.
- DATA  out  8*LANES  beat data; lane l = DATA[8l+7:8l].
- K  out  LANES  per-lane K-symbol flag (1 on COM bytes).
- Valid  out  1  beat present.
- frame_done  out  1  one-cycle pulse on transfer of a frame's last payload beat.
- frame_cnt  out  16  completed frames, wraps 16'hFFFF -> 0.

Behaviour:
- Transfer: a beat transfers on a rising edge with Valid && ready. While Valid=1 and ready=0, DATA, K and Valid hold stable.
- All outputs are registered.
- Reset (reset=0, async): Valid=0, DATA=0, K=0, frame_done=0, frame_cnt=0, state IDLE, beat counter 0.
- States:
  - IDLE: Valid=0. On an edge with enable=1: latch mode and seed, go to SYNC. The first COM beat is presented the next cycle, so enable-to-Valid latency is 1 cycle.
  - SYNC: every lane = COM, K = all ones. After SYNC_LEN transfers, go to PAYLOAD.
  - PAYLOAD: K = 0. On the PAYLOAD_LEN-th transfer:
    - pulse frame_done and increment frame_cnt in the same edge.
    - if enable=1: relatch mode/seed, go to SYNC. The next COM beat follows with no bubble.
    - else: go to IDLE, with Valid=0 the next cycle.
- enable dropped mid-frame: the current frame completes, then the block goes to IDLE. Frames are never truncated.
- Counter payload: byte index p = beat*LANES + lane, 0..PAYLOAD_LEN*LANES-1, restarting each frame. Byte = (seed + p) mod 256.
- LFSR payload:
  - step(s) = {s[6:0], s[7]^s[5]^s[4]^s[3]}.
  - State loads seed at frame start; seed 0 loads 8'hFF instead.
  - Lane l of a beat = state stepped l times.
  - On transfer, the state advances LANES steps (combinational unroll).
- Payload bytes equal to COM are legal; K=0 distinguishes them.
- frame_done is high only for the single cycle after the last payload transfer edge. It is not held under backpressure.
- Reset asserted mid-frame: immediate return to reset values; no partial-frame completion.
- mode/seed changes mid-frame are ignored until the next latch.

Test Plan:
- LANES=1, SYNC_LEN=2, PAYLOAD_LEN=4, mode=0, seed=8'h25, ready=1, enable held:
  - DATA/K = BC/1, BC/1, 25/0, 26/0, 27/0, 28/0, then repeat BC, BC, 25…
  - frame_done pulses once per 6 beats; frame_cnt increments 1, 2, 3.
- Same setup, mode=1, seed=8'h01: payload 01, 02, 04, 08. Second run with seed=0: first payload byte FF.
- LANES=4, PAYLOAD_LEN=2, mode=0, seed=8'hFE:
  - COM beat DATA=BCBCBCBC, K=4'hF.
  - payload beats 0x0100FFFE, 0x05040302 (lane 0 in LSB); counter wrap FF->00 verified.
- Backpressure with ready toggling 1,0,0,1 during PAYLOAD: DATA/K/Valid held while ready=0; no beat skipped or duplicated; sequence identical to the ready=1 run.
- enable dropped during the 2nd COM beat: frame completes with all 4 payload beats, frame_done pulses, Valid=0 next cycle, state IDLE, no new COM.
- Async reset=0 mid-PAYLOAD, between clock edges: Valid, DATA, K and frame_cnt clear immediately. After release with enable=1, output restarts with BC beats.

Source files
------------

// File: rtl/pcie_gen_tramas.sv
`default_nettype none
// ============================================================================
// Module      : pcie_gen_tramas
// Description : Frame source for the ByteTX byte interface. Each frame is
//               SYNC_LEN COM beats followed by PAYLOAD_LEN payload beats.
//               Payload is counter or LFSR generated and flows under a
//               Valid/ready handshake over LANES byte lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module pcie_gen_tramas #(
    parameter int          LANES       = 1,
    parameter int          SYNC_LEN    = 2,
    parameter int          PAYLOAD_LEN = 4,
    parameter logic [7:0]  COM         = 8'hBC
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 mode,
    input  logic [7:0]           seed,
    input  logic                 ready,
    output logic [8*LANES-1:0]   DATA,
    output logic [LANES-1:0]     K,
    output logic                 Valid,
    output logic                 frame_done,
    output logic [15:0]          frame_cnt
);

    localparam int MAXLEN = (SYNC_LEN > PAYLOAD_LEN) ? SYNC_LEN : PAYLOAD_LEN;
    localparam int CW     = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;

    localparam logic [CW-1:0]        C_SYNC_LAST = CW'(SYNC_LEN - 1);
    localparam logic [CW-1:0]        C_PAY_LAST  = CW'(PAYLOAD_LEN - 1);
    localparam logic [8*LANES-1:0]   C_COM_BEAT  = {LANES{COM}};
    localparam logic [LANES-1:0]     C_K_ALL     = {LANES{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SYNC    = 2'd1,
        S_PAYLOAD = 2'd2
    } state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_beat;
    logic                   r_mode;
    logic [7:0]             r_cnt;      // counter byte for lane 0 of the next payload beat
    logic [7:0]             r_lfsr;     // LFSR state for lane 0 of the next payload beat
    logic [8*LANES-1:0]     r_data;
    logic [LANES-1:0]       r_k;
    logic                   r_valid;
    logic                   r_done;
    logic [15:0]            r_fcnt;

    logic [8*LANES-1:0]     w_cnt_beat;
    logic [8*LANES-1:0]     w_lfsr_beat;
    logic [7:0]             w_lfsr_next;
    logic [7:0]             w_lfsr_tmp;
    logic [8*LANES-1:0]     w_pay_beat;
    logic [7:0]             w_seed_lfsr;
    logic                   w_xfer;

    function automatic logic [7:0] f_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // Build the next payload beat: counter bytes and LFSR unrolled across lanes
    always_comb begin
        w_cnt_beat  = '0;
        w_lfsr_beat = '0;
        w_lfsr_tmp  = r_lfsr;
        for (int l = 0; l < LANES; l++) begin
            w_cnt_beat[8*l +: 8]  = r_cnt + 8'(l);
            w_lfsr_beat[8*l +: 8] = w_lfsr_tmp;
            w_lfsr_tmp            = f_step(w_lfsr_tmp);
        end
        w_lfsr_next = w_lfsr_tmp;
    end

    assign w_pay_beat  = r_mode ? w_lfsr_beat : w_cnt_beat;
    assign w_seed_lfsr = (seed == 8'h00) ? 8'hFF : seed;   // all-zero LFSR state would lock up
    assign w_xfer      = r_valid & ready;

    // Frame sequencer: outputs always hold the beat currently on offer
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
            r_mode  <= 1'b0;
            r_cnt   <= 8'h00;
            r_lfsr  <= 8'h00;
            r_data  <= '0;
            r_k     <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_fcnt  <= 16'h0000;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_mode  <= mode;
                        r_cnt   <= seed;
                        r_lfsr  <= w_seed_lfsr;
                        r_state <= S_SYNC;
                        r_beat  <= '0;
                        r_valid <= 1'b1;
                        r_data  <= C_COM_BEAT;
                        r_k     <= C_K_ALL;
                    end
                end
                S_SYNC: begin
                    if (w_xfer) begin
                        if (r_beat == C_SYNC_LAST) begin
                            r_state <= S_PAYLOAD;
                            r_beat  <= '0;
                            r_data  <= w_pay_beat;
                            r_k     <= '0;
                            r_cnt   <= r_cnt + 8'(LANES);
                            r_lfsr  <= w_lfsr_next;
                        end else begin
                            r_beat <= r_beat + CW'(1);
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (w_xfer) begin
                        if (r_beat == C_PAY_LAST) begin
                            r_done <= 1'b1;
                            r_fcnt <= r_fcnt + 16'h0001;
                            r_beat <= '0;
                            if (enable) begin
                                r_mode  <= mode;
                                r_cnt   <= seed;
                                r_lfsr  <= w_seed_lfsr;
                                r_state <= S_SYNC;
                                r_data  <= C_COM_BEAT;
                                r_k     <= C_K_ALL;
                            end else begin
                                r_state <= S_IDLE;
                                r_valid <= 1'b0;
                                r_data  <= '0;
                                r_k     <= '0;
                            end
                        end else begin
                            r_beat <= r_beat + CW'(1);
                            r_data <= w_pay_beat;
                            r_cnt  <= r_cnt + 8'(LANES);
                            r_lfsr <= w_lfsr_next;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign DATA       = r_data;
    assign K          = r_k;
    assign Valid      = r_valid;
    assign frame_done = r_done;
    assign frame_cnt  = r_fcnt;

endmodule
`default_nettype wire
